moven_logic: RTL and testbench



---
 rtl/moven_logic_if.sv | 20 ++
 rtl/moven_logic.sv | 105 ++++++++++
 tb/tb_moven_logic.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/moven_logic_if.sv
// Move-tick / position bus between the game timer, the formation
// movement controller and the enemy sprite renderer.
interface moven_logic_if;
  // Move-tick level from the game timer; its rising edge requests one step.
  logic        mueva;
  // Formation left-edge pixel column, registered inside the controller.
  logic [10:0] posxE1;

  // Timer/renderer side: drives the tick, observes the position.
  modport master (
    output mueva,
    input  posxE1
  );

  // Controller side: consumes the tick, produces the position.
  modport slave (
    input  mueva,
    output posxE1
  );
endinterface : moven_logic_if

// File: rtl/moven_logic.sv
// Horizontal movement controller for the enemy formation.
// Each rising edge of the move-tick advances the formation by STEP pixels.
// The formation bounces between X_MIN and X_MAX, and both limits are inclusive.
// A step that would reach or cross a limit clamps the position to that limit.
// The direction flips on that same step.
module moven_logic #(
  parameter int X_START = 100,
  parameter int X_MIN   = 32,
  parameter int X_MAX   = 560,
  parameter int STEP    = 8
) (
  input  logic          clk,
  input  logic          reset,
  moven_logic_if.slave  bus
);

  // Formation direction; RIGHT means increasing x.
  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  // 12-bit constants.
  // Sums and limits share one unsigned width, so pos + STEP can never wrap.
  localparam logic [11:0] XMAX_W     = 12'(X_MAX);
  localparam logic [11:0] XMIN_W     = 12'(X_MIN);
  localparam logic [11:0] STEP_W     = 12'(STEP);
  // Compare pos against X_MIN + STEP instead of computing pos - STEP first.
  // The left-limit test then never depends on an underflowed difference.
  localparam logic [11:0] LEFT_GUARD = 12'(X_MIN + STEP);
  localparam logic [10:0] XSTART_P   = 11'(X_START);
  localparam logic [10:0] XMIN_P     = 11'(X_MIN);
  localparam logic [10:0] XMAX_P     = 11'(X_MAX);

  dir_e        dir_q, dir_d;
  logic [10:0] pos_q, pos_d;
  logic        mueva_q;
  logic        tick;
  logic [11:0] pos_w;
  logic [11:0] pos_up;
  logic [11:0] pos_dn;

  // A tick is the first clock at which mueva is seen high after being low.
  assign tick   = bus.mueva & ~mueva_q;

  assign pos_w  = {1'b0, pos_q};
  assign pos_up = pos_w + STEP_W;
  assign pos_dn = pos_w - STEP_W;

  // State register: position, direction and the previous mueva sample.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q   <= XSTART_P;
      dir_q   <= DIR_RIGHT;
      mueva_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      mueva_q <= bus.mueva;
    end
  end

  // Next-state logic: step, clamp at a limit and flip direction on a tick.
  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (tick) begin
      unique case (dir_q)
        DIR_RIGHT: begin
          if (pos_up < XMAX_W) begin
            pos_d = pos_up[10:0];
          end else begin
            pos_d = XMAX_P;
            dir_d = DIR_LEFT;
          end
        end
        DIR_LEFT: begin
          if (pos_w > LEFT_GUARD) begin
            pos_d = pos_dn[10:0];
          end else begin
            pos_d = XMIN_P;
            dir_d = DIR_RIGHT;
          end
        end
        default: begin
          pos_d = pos_q;
          dir_d = dir_q;
        end
      endcase
    end
  end

  // The renderer sees the registered position only, with no path from mueva.
  assign bus.posxE1 = pos_q;

  // XMIN_W is kept for symmetry with XMAX_W.
  // The left test goes through LEFT_GUARD, so XMIN_W drives no logic.
  logic unused_ok;
  assign unused_ok = ^XMIN_W;

endmodule : moven_logic

// File: tb/tb_moven_logic.sv
// Directed bench for moven_logic.
// It covers idle hold, a single step, level-held mueva, the right clamp,
// the exact left landing, an asynchronous mid-run reset and a tick at
// reset release.
module tb_moven_logic;

  logic clk;
  logic reset;

  int checks;
  int failures;

  moven_logic_if bus ();

  moven_logic dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 20 ns clock.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [10:0] got,
                       input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse mueva for one clock, then hold it low for one clock.
  // The position is sampled one time unit after the stepping edge.
  task automatic tick_and_sample(output logic [10:0] val);
    @(negedge clk);
    bus.mueva = 1'b1;
    @(posedge clk);
    #1 val = bus.posxE1;
    @(negedge clk);
    bus.mueva = 1'b0;
  endtask

  task automatic ticks(input int n);
    logic [10:0] v;
    for (int i = 0; i < n; i++) tick_and_sample(v);
  endtask

  initial begin
    logic [10:0] v;
    logic        idle_ok;
    logic        hold_ok;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.mueva = 1'b0;

    // Reset pulse, 120 ns to 140 ns.
    #120 reset = 1'b1;
    #1 check("reset_async", bus.posxE1, 11'd100);
    #19 reset = 1'b0;

    // Idle: mueva stays low for 1000 clocks, so the position holds.
    idle_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.posxE1 !== 11'd100) idle_ok = 1'b0;
    end
    check("idle_hold_end", bus.posxE1, 11'd100);
    check("idle_hold_all", {10'd0, idle_ok}, 11'd1);

    // Single tick: 108 right after the edge that samples mueva high.
    // This also shows the direction was RIGHT.
    @(negedge clk);
    bus.mueva = 1'b1;
    @(posedge clk);
    #1 check("single_tick", bus.posxE1, 11'd108);
    // Hold mueva high for 50 clocks: no further step.
    hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.posxE1 !== 11'd108) hold_ok = 1'b0;
    end
    check("held_high_end", bus.posxE1, 11'd108);
    check("held_high_all", {10'd0, hold_ok}, 11'd1);
    @(negedge clk);
    bus.mueva = 1'b0;

    // Ticks 2..57 bring the position to 100 + 57*8 = 556.
    ticks(55);
    tick_and_sample(v);
    check("tick57", v, 11'd556);
    tick_and_sample(v);
    check("tick58_clamp", v, 11'd560);
    tick_and_sample(v);
    check("tick59_left", v, 11'd552);

    // From 560 moving left: 552 is tick 1, so 64 more reach 40.
    ticks(64);
    check("left_40", bus.posxE1, 11'd40);
    // Tick 66 lands exactly on 32 and flips the direction.
    tick_and_sample(v);
    check("left_exact32", v, 11'd32);
    tick_and_sample(v);
    check("after_left_bounce", v, 11'd40);

    // Mid-operation async reset: return to 100, then 25 ticks reach 300.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_again", bus.posxE1, 11'd100);
    ticks(25);
    check("reach_300", bus.posxE1, 11'd300);
    @(posedge clk);
    #5 reset = 1'b1;
    #1 check("async_mid", bus.posxE1, 11'd100);
    @(negedge clk);
    reset = 1'b0;
    tick_and_sample(v);
    check("after_mid_reset", v, 11'd108);

    // Tick at reset release: mueva is already high while reset falls.
    ticks(10);
    check("pre_release_pos", bus.posxE1, 11'd188);
    @(negedge clk);
    reset = 1'b1;
    bus.mueva = 1'b1;
    #2 check("release_in_reset", bus.posxE1, 11'd100);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 check("release_tick", bus.posxE1, 11'd108);
    repeat (5) @(negedge clk);
    check("release_held", bus.posxE1, 11'd108);
    bus.mueva = 1'b0;
    // A low period followed by a new rising edge gives one more step.
    tick_and_sample(v);
    check("release_next", v, 11'd116);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time bound: the run ends by itself even if the sequence stalls.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got stalled expected finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_moven_logic
